// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller and its password datapath:
// controller state codes, default sizing, the blank display code and a
// helper that identifies the states in which keypad digits are collected.
package lock_pkg;

    // Controller current_state encoding (5-bit code on the ctrl_state bus)
    typedef enum logic [4:0] {
        S0   = 5'd0,
        S1   = 5'd1,   // set-password
        S2   = 5'd2,
        S3   = 5'd3,   // verify
        S4   = 5'd4,   // controller samples the flags here
        S5   = 5'd5,
        S6   = 5'd6,
        IDLE = 5'd7
    } ctrl_state_e;

    localparam int DEF_DIGITS   = 4;
    localparam int DEF_MAX_FAIL = 3;

    // Nibble shown in place of a hidden digit on the 7-seg driver
    localparam logic [3:0] DASH_CODE = 4'hA;

    // Digits are collected only while setting or verifying a password
    function automatic logic is_entry_state(input logic [4:0] state);
        return (state == S1) || (state == S3);
    endfunction

endpackage

// File: rtl/digit_shift_buffer.sv
// Keypad entry buffer: a nibble shift register with a fill count.
// New digits enter the LSB nibble and older digits move up; once DIGITS
// digits are held, further shift requests are dropped (saturation).
// clr has priority over shift_req.
module digit_shift_buffer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  shift_req,
    input  logic [3:0]            din,
    output logic [4*DIGITS-1:0]   data_q,
    output logic [2:0]            cnt_q
);

    localparam logic [2:0] DIGITS_W = 3'(DIGITS);

    logic [4*DIGITS-1:0] data_d;
    logic [2:0]          cnt_d;
    logic                full;

    // Next buffer contents: clear, shift-in, or hold
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        full   = (cnt_q >= DIGITS_W);
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift_req && !full) begin
            data_d = {data_q[4*DIGITS-5:0], din};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    // Buffer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pwd_verify_unit.sv
// Password store-and-compare datapath feeding the lock controller.
// Collects digits in S1 (set) and S3 (verify), latches the password on
// enter in S1 and compares on enter in S3, producing the match (gled1),
// single-failure (rled1) and sticky lockout (rled2) flags.
// Build option: PWD_MASK_DISPLAY_EN hides entered digits on disp_code
// (each filled nibble shows DASH_CODE); without it disp_code is the raw
// entry buffer.
//
// Handshake: key_valid and enter are single-cycle strobes with no
// back-pressure; a strobe is consumed in the cycle it is high or lost.
// enter beats key_valid in the same cycle, and a state-entry clear beats
// both.
module pwd_verify_unit
    import lock_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int MAX_FAIL = DEF_MAX_FAIL,
    parameter int CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            ctrl_state,
    input  logic                  key_valid,
    input  logic [3:0]            key_val,
    input  logic                  enter,
    output logic                  gled1,
    output logic                  rled1,
    output logic                  rled2,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [2:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   disp_code
);

    localparam logic [2:0]     DIGITS_W   = 3'(DIGITS);
    localparam logic [CNT_W:0] MAX_FAIL_X = (CNT_W+1)'(MAX_FAIL);

    // Registered state
    logic [4:0]          prev_state_q, prev_state_d;
    logic [4*DIGITS-1:0] pwd_reg_q, pwd_reg_d;
    logic                pwd_valid_q, pwd_valid_d;
    logic                gled1_q, gled1_d;
    logic                rled1_q, rled1_d;
    logic                rled2_q, rled2_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;

    // Entry buffer
    logic [4*DIGITS-1:0] buf_data;
    logic [2:0]          buf_cnt;

    // Decoded strobes
    logic                state_entry;
    logic                buf_clr;
    logic                accepting;
    logic                enter_ok;
    logic                shift_req;
    logic                commit;
    logic                evaluate;
    logic                match;
    logic [CNT_W:0]      fail_inc;
    logic [CNT_W-1:0]    fail_sat;

    // Decode entry clears, accepted strobes and the compare result
    always_comb begin
        state_entry = (ctrl_state != prev_state_q);
        buf_clr     = state_entry && is_entry_state(ctrl_state);
        // Lockout freezes the datapath; an entry clear still wins over keys
        accepting   = is_entry_state(ctrl_state) && !buf_clr && !rled2_q;
        enter_ok    = accepting && enter;
        shift_req   = accepting && !enter && key_valid && (key_val <= 4'd9);
        commit      = enter_ok && (ctrl_state == S1);
        evaluate    = enter_ok && (ctrl_state == S3);
        // A short entry or an unset password never matches
        match       = pwd_valid_q && (buf_cnt == DIGITS_W) && (buf_data == pwd_reg_q);
        fail_inc    = {1'b0, fail_cnt_q} + (CNT_W+1)'(1);
        fail_sat    = (fail_inc >= MAX_FAIL_X) ? MAX_FAIL_X[CNT_W-1:0]
                                               : fail_inc[CNT_W-1:0];
    end

    // Next values of the stored password, fail counter and result flags
    always_comb begin
        prev_state_d = ctrl_state;
        pwd_reg_d    = pwd_reg_q;
        pwd_valid_d  = pwd_valid_q;
        gled1_d      = gled1_q;
        rled1_d      = rled1_q;
        rled2_d      = rled2_q;
        fail_cnt_d   = fail_cnt_q;

        if (buf_clr) begin
            gled1_d = 1'b0;
            if (ctrl_state == S3) begin
                rled1_d = 1'b0;
            end
        end else if (commit) begin
            pwd_reg_d   = buf_data;
            pwd_valid_d = 1'b1;
            fail_cnt_d  = '0;
            rled1_d     = 1'b0;
        end else if (evaluate) begin
            if (match) begin
                gled1_d    = 1'b1;
                rled1_d    = 1'b0;
                fail_cnt_d = '0;
            end else begin
                fail_cnt_d = fail_sat;
                if ({1'b0, fail_sat} == MAX_FAIL_X) begin
                    rled2_d = 1'b1;
                    rled1_d = 1'b0;
                end else begin
                    rled1_d = 1'b1;
                end
            end
        end
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_state_q <= IDLE;
            pwd_reg_q    <= '0;
            pwd_valid_q  <= 1'b0;
            gled1_q      <= 1'b0;
            rled1_q      <= 1'b0;
            rled2_q      <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            prev_state_q <= prev_state_d;
            pwd_reg_q    <= pwd_reg_d;
            pwd_valid_q  <= pwd_valid_d;
            gled1_q      <= gled1_d;
            rled1_q      <= rled1_d;
            rled2_q      <= rled2_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    digit_shift_buffer #(
        .DIGITS    (DIGITS)
    ) u_digit_buf (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (buf_clr),
        .shift_req (shift_req),
        .din       (key_val),
        .data_q    (buf_data),
        .cnt_q     (buf_cnt)
    );

`ifdef PWD_MASK_DISPLAY_EN
    logic [4*DIGITS-1:0] disp_mask;

    // Show a dash in every filled nibble position, newest at the LSB
    always_comb begin
        disp_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(buf_cnt)) begin
                disp_mask[4*i +: 4] = DASH_CODE;
            end
        end
    end

    assign disp_code = disp_mask;
`else
    assign disp_code = buf_data;
`endif

    assign gled1     = gled1_q;
    assign rled1     = rled1_q;
    assign rled2     = rled2_q;
    assign fail_cnt  = fail_cnt_q;
    assign digit_cnt = buf_cnt;

endmodule
